// File: rtl/ad7643_serial_capture_if.sv
// Signal bundle between the AD7643 serial capture block and its environment:
// the run/clear controls, the ADC pins (chip select, convert start, serial clock,
// serial data, busy) and the sample handshake toward the capture memory.
//
// Modports:
//   master - the capture block (drives the ADC control pins and the sample side)
//   slave  - the environment (drives RUN/CLR/READY and the ADC return pins)
interface ad7643_serial_capture_if #(
  parameter int unsigned DATA_BITS = 18
) ();
  logic                 RUN;
  logic                 CLR;
  logic                 ADCS;
  logic                 ADCNVST;
  logic                 ADSCLK;
  logic                 ADSDOUT;
  logic                 ADBUSY;
  logic [DATA_BITS-1:0] SAMPLE;
  logic                 SAMPLE_VALID;
  logic                 SAMPLE_READY;
  logic [31:0]          SAMPLE_CNT;
  logic                 OVERRUN;
  logic                 TIMEOUT_ERR;
  logic                 ACTIVE;

  modport master (
    input  RUN, CLR, ADSDOUT, ADBUSY, SAMPLE_READY,
    output ADCS, ADCNVST, ADSCLK, SAMPLE, SAMPLE_VALID, SAMPLE_CNT, OVERRUN, TIMEOUT_ERR,
           ACTIVE
  );

  modport slave (
    output RUN, CLR, ADSDOUT, ADBUSY, SAMPLE_READY,
    input  ADCS, ADCNVST, ADSCLK, SAMPLE, SAMPLE_VALID, SAMPLE_CNT, OVERRUN, TIMEOUT_ERR,
           ACTIVE
  );
endinterface

// File: rtl/ad7643_serial_capture.sv
// Single-channel AD7643 acquisition in serial-slave mode. Each conversion:
// CNVST pulse, wait for BUSY to rise and fall, clock DATA_BITS bits in MSB first,
// then offer the word on a valid/ready handshake. Conversions repeat no faster
// than one per CONV_PERIOD clocks while RUN is high.
//
// Ports:
//   CLK    - system clock, all logic on its rising edge
//   RESETN - asynchronous active-low reset
//   bus    - master side of ad7643_serial_capture_if:
//            RUN/CLR controls, ADCS/ADCNVST/ADSCLK to the ADC, ADSDOUT/ADBUSY from it,
//            SAMPLE/SAMPLE_VALID/SAMPLE_READY handshake, SAMPLE_CNT, sticky OVERRUN and
//            TIMEOUT_ERR flags, ACTIVE status.
module ad7643_serial_capture #(
  parameter int unsigned CONV_PERIOD  = 250,
  parameter int unsigned CNVST_WIDTH  = 4,
  parameter int unsigned SCLK_HALF    = 2,
  parameter int unsigned DATA_BITS    = 18,
  parameter int unsigned BUSY_TIMEOUT = 400
) (
  input logic                      CLK,
  input logic                      RESETN,
  ad7643_serial_capture_if.master  bus
);

  localparam int unsigned PerW   = $clog2(CONV_PERIOD + 1);
  localparam int unsigned CntMax = (BUSY_TIMEOUT > CNVST_WIDTH) ? BUSY_TIMEOUT : CNVST_WIDTH;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned BitW   = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    StIdle,
    StConv,
    StWaitHi,
    StWaitLo,
    StShift,
    StDone,
    StGap
  } state_e;

  state_e               state_q, state_d;
  logic                 busy_meta_q, busy_sync_q;
  logic [PerW-1:0]      per_cnt_q, per_cnt_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [7:0]           half_q, half_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic                 sclk_q, sclk_d;
  logic [DATA_BITS-1:0] sr_q, sr_d;
  logic [DATA_BITS-1:0] sample_q, sample_d;
  logic                 valid_q, valid_d;
  logic [31:0]          scnt_q, scnt_d;
  logic                 overrun_q, overrun_d;
  logic                 timeout_q, timeout_d;
  logic                 adcs_q, adcs_d;
  logic                 cnvst_q, cnvst_d;
  logic                 active_q, active_d;
  logic                 accept;
  logic                 load;
  logic                 timeout_hit;

  assign accept = valid_q & bus.SAMPLE_READY;

  // FSM next state, SCLK generation and shift register.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    half_d      = half_q;
    bit_d       = bit_q;
    sclk_d      = sclk_q;
    sr_d        = sr_q;
    load        = 1'b0;
    timeout_hit = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.RUN) begin
          state_d = StConv;
          cnt_d   = '0;
        end
      end

      StConv: begin
        if (cnt_q == CntW'(CNVST_WIDTH - 1)) begin
          state_d = StWaitHi;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StWaitHi: begin
        if (busy_sync_q) begin
          state_d = StWaitLo;
          cnt_d   = '0;
        end else if (cnt_q == CntW'(BUSY_TIMEOUT - 1)) begin
          state_d     = StGap;
          timeout_hit = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StWaitLo: begin
        if (!busy_sync_q) begin
          state_d = StShift;
          half_d  = '0;
          bit_d   = '0;
          sclk_d  = 1'b0;
        end else if (cnt_q == CntW'(BUSY_TIMEOUT - 1)) begin
          state_d     = StGap;
          timeout_hit = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StShift: begin
        if (half_q == 8'(SCLK_HALF - 1)) begin
          half_d = '0;
          sclk_d = ~sclk_q;
          // Data is taken on the edge that drives SCLK high -> low.
          if (sclk_q) begin
            sr_d  = {sr_q[DATA_BITS-2:0], bus.ADSDOUT};
            bit_d = bit_q + 1'b1;
            if (bit_q == BitW'(DATA_BITS - 1)) begin
              state_d = StDone;
            end
          end
        end else begin
          half_d = half_q + 1'b1;
        end
      end

      StDone: begin
        // A word being taken this very cycle frees the output register.
        load    = ~valid_q | accept;
        state_d = StGap;
      end

      StGap: begin
        // The period counter reaches CONV_PERIOD on this edge, so the next CNVST
        // lands exactly CONV_PERIOD clocks after the previous one.
        if (per_cnt_q >= PerW'(CONV_PERIOD - 1)) begin
          state_d = bus.RUN ? StConv : StIdle;
          cnt_d   = '0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Period counter, handshake, sticky flags and registered pin outputs.
  always_comb begin
    per_cnt_d = per_cnt_q;
    if (state_d == StConv && state_q != StConv) begin
      per_cnt_d = '0;
    end else if (per_cnt_q != PerW'(CONV_PERIOD)) begin
      per_cnt_d = per_cnt_q + 1'b1;
    end

    sample_d = load ? sr_q : sample_q;

    valid_d = valid_q;
    if (load) begin
      valid_d = 1'b1;
    end else if (accept) begin
      valid_d = 1'b0;
    end

    scnt_d = scnt_q;
    if (bus.CLR) begin
      scnt_d = accept ? 32'd1 : 32'd0;
    end else if (accept) begin
      scnt_d = scnt_q + 32'd1;
    end

    // Set wins over CLR for both sticky flags.
    overrun_d = overrun_q;
    if (state_q == StDone && !load) begin
      overrun_d = 1'b1;
    end else if (bus.CLR) begin
      overrun_d = 1'b0;
    end

    timeout_d = timeout_q;
    if (timeout_hit) begin
      timeout_d = 1'b1;
    end else if (bus.CLR) begin
      timeout_d = 1'b0;
    end

    adcs_d   = !(state_d inside {StConv, StWaitHi, StWaitLo, StShift});
    cnvst_d  = (state_d == StConv);
    active_d = (state_d != StIdle);
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q     <= StIdle;
      busy_meta_q <= 1'b0;
      busy_sync_q <= 1'b0;
      per_cnt_q   <= '0;
      cnt_q       <= '0;
      half_q      <= '0;
      bit_q       <= '0;
      sclk_q      <= 1'b0;
      sr_q        <= '0;
      sample_q    <= '0;
      valid_q     <= 1'b0;
      scnt_q      <= '0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
      adcs_q      <= 1'b1;
      cnvst_q     <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_meta_q <= bus.ADBUSY;
      busy_sync_q <= busy_meta_q;
      per_cnt_q   <= per_cnt_d;
      cnt_q       <= cnt_d;
      half_q      <= half_d;
      bit_q       <= bit_d;
      sclk_q      <= sclk_d;
      sr_q        <= sr_d;
      sample_q    <= sample_d;
      valid_q     <= valid_d;
      scnt_q      <= scnt_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
      adcs_q      <= adcs_d;
      cnvst_q     <= cnvst_d;
      active_q    <= active_d;
    end
  end

  assign bus.ADCS         = adcs_q;
  assign bus.ADCNVST      = cnvst_q;
  assign bus.ADSCLK       = sclk_q;
  assign bus.SAMPLE       = sample_q;
  assign bus.SAMPLE_VALID = valid_q;
  assign bus.SAMPLE_CNT   = scnt_q;
  assign bus.OVERRUN      = overrun_q;
  assign bus.TIMEOUT_ERR  = timeout_q;
  assign bus.ACTIVE       = active_q;

endmodule

// File: tb/tb_ad7643_serial_capture.sv
// Directed bench for ad7643_serial_capture. dut1 uses default timing, dut2 uses
// SCLK_HALF=1. Small ADC models answer CNVST with a 160-cycle BUSY pulse and shift
// a preset word out MSB first, advancing on each ADSCLK falling edge.
module tb_ad7643_serial_capture;

  localparam logic [17:0] Word2 = 18'h2AAAA;
  localparam int SelCnvst1 = 0, SelValid1 = 1, SelSclk1 = 2, SelTmo1 = 3, SelActive1 = 4;
  localparam int SelOvr1 = 5, SelCnvst2 = 6;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  int unsigned cyc = 0;
  int unsigned total = 0;
  int unsigned passed = 0;
  logic [17:0] adc_word1 = '0;
  logic [17:0] sh1 = '0;
  logic [17:0] sh2 = '0;
  bit          busy_en = 1'b1;
  int unsigned falls2 = 0;

  ad7643_serial_capture_if #(.DATA_BITS(18)) bus1 ();
  ad7643_serial_capture_if #(.DATA_BITS(18)) bus2 ();

  ad7643_serial_capture dut1 (
    .CLK    (CLK),
    .RESETN (RESETN),
    .bus    (bus1)
  );

  ad7643_serial_capture #(.SCLK_HALF(1)) dut2 (
    .CLK    (CLK),
    .RESETN (RESETN),
    .bus    (bus2)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // ADC serial data models.
  always @(posedge bus1.ADCNVST or negedge bus1.ADSCLK) begin
    if (bus1.ADCNVST) sh1 = adc_word1;
    else sh1 = sh1 << 1;
    bus1.ADSDOUT = sh1[17];
  end

  always @(posedge bus2.ADCNVST or negedge bus2.ADSCLK) begin
    if (bus2.ADCNVST) sh2 = Word2;
    else begin
      sh2 = sh2 << 1;
      falls2 = falls2 + 1;
    end
    bus2.ADSDOUT = sh2[17];
  end

  // ADC busy models.
  initial begin
    bus1.ADBUSY = 1'b0;
    forever begin
      @(posedge bus1.ADCNVST);
      if (busy_en) begin
        @(negedge CLK);
        bus1.ADBUSY = 1'b1;
        repeat (160) @(negedge CLK);
        bus1.ADBUSY = 1'b0;
      end
    end
  end

  initial begin
    bus2.ADBUSY = 1'b0;
    forever begin
      @(posedge bus2.ADCNVST);
      @(negedge CLK);
      bus2.ADBUSY = 1'b1;
      repeat (160) @(negedge CLK);
      bus2.ADBUSY = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      SelCnvst1:  return bus1.ADCNVST;
      SelValid1:  return bus1.SAMPLE_VALID;
      SelSclk1:   return bus1.ADSCLK;
      SelTmo1:    return bus1.TIMEOUT_ERR;
      SelActive1: return bus1.ACTIVE;
      SelOvr1:    return bus1.OVERRUN;
      SelCnvst2:  return bus2.ADCNVST;
      default:    return 1'b0;
    endcase
  endfunction

  // Waits (at negedges) until the selected signal equals val; a timeout is a failure.
  task automatic wait_level(input string tag, input int sel, input logic val, input int limit,
                            output int unsigned at);
    bit hit = 1'b0;
    for (int i = 0; i <= limit; i++) begin
      if (sig(sel) === val) begin
        hit = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    at = cyc;
    if (!hit) begin
      total++;
      $error("FAIL %s: signal %0d never reached %0b within %0d cycles", tag, sel, val, limit);
    end
  endtask

  task automatic wait_rise(input string tag, input int sel, input int limit,
                           output int unsigned at);
    int unsigned dummy;
    wait_level(tag, sel, 1'b0, limit, dummy);
    wait_level(tag, sel, 1'b1, limit, at);
  endtask

  initial begin
    int unsigned t0, t1, t2, t3, t4, t5, t6, at;
    int unsigned n, n2, first, last, f0;

    bus1.RUN = 1'b0; bus1.CLR = 1'b0; bus1.SAMPLE_READY = 1'b0;
    bus2.RUN = 1'b0; bus2.CLR = 1'b0; bus2.SAMPLE_READY = 1'b1;

    // Reset state.
    repeat (3) @(negedge CLK);
    chk("rst_adcs", 32'(bus1.ADCS), 32'd1);
    chk("rst_cnvst", 32'(bus1.ADCNVST), 32'd0);
    chk("rst_sclk", 32'(bus1.ADSCLK), 32'd0);
    chk("rst_sample", 32'(bus1.SAMPLE), 32'd0);
    chk("rst_valid", 32'(bus1.SAMPLE_VALID), 32'd0);
    chk("rst_cnt", bus1.SAMPLE_CNT, 32'd0);
    chk("rst_flags", 32'({bus1.OVERRUN, bus1.TIMEOUT_ERR, bus1.ACTIVE}), 32'd0);
    RESETN = 1'b1;
    repeat (3) @(negedge CLK);
    chk("idle_active", 32'(bus1.ACTIVE), 32'd0);

    // Normal conversion with READY held high.
    adc_word1 = 18'h2A5A5;
    bus1.SAMPLE_READY = 1'b1;
    bus1.RUN = 1'b1;
    wait_rise("cnvst0", SelCnvst1, 50, t0);
    adc_word1 = 18'h00001;
    chk("conv_adcs_low", 32'(bus1.ADCS), 32'd0);
    chk("conv_active", 32'(bus1.ACTIVE), 32'd1);
    repeat (3) @(negedge CLK);
    chk("cnvst_high_4", 32'(bus1.ADCNVST), 32'd1);
    @(negedge CLK);
    chk("cnvst_low_5", 32'(bus1.ADCNVST), 32'd0);
    wait_rise("valid0", SelValid1, 300, at);
    chk("valid0_time", at - t0, 32'd236);
    chk("sample0", 32'(bus1.SAMPLE), 32'h2A5A5);
    chk("sample0_adcs", 32'(bus1.ADCS), 32'd1);
    @(negedge CLK);
    chk("valid0_one_cycle", 32'(bus1.SAMPLE_VALID), 32'd0);
    chk("cnt_after_0", bus1.SAMPLE_CNT, 32'd1);
    wait_rise("cnvst1", SelCnvst1, 300, t1);
    chk("period_250", t1 - t0, 32'd250);

    // READY low across two conversions: the second word is dropped.
    bus1.SAMPLE_READY = 1'b0;
    adc_word1 = 18'h3FFFF;
    wait_rise("cnvst2", SelCnvst1, 300, t2);
    adc_word1 = 18'h15A3C;
    wait_level("overrun", SelOvr1, 1'b1, 400, at);
    chk("overrun_time", at - t2, 32'd236);
    chk("ovr_sample_kept", 32'(bus1.SAMPLE), 32'h00001);
    chk("ovr_valid", 32'(bus1.SAMPLE_VALID), 32'd1);
    chk("ovr_cnt", bus1.SAMPLE_CNT, 32'd1);
    bus1.SAMPLE_READY = 1'b1;
    bus1.CLR = 1'b1;
    @(negedge CLK);
    bus1.CLR = 1'b0;
    chk("clr_accept_cnt", bus1.SAMPLE_CNT, 32'd1);
    chk("clr_accept_valid", 32'(bus1.SAMPLE_VALID), 32'd0);
    chk("clr_overrun", 32'(bus1.OVERRUN), 32'd0);
    bus1.CLR = 1'b1;
    @(negedge CLK);
    bus1.CLR = 1'b0;
    chk("clr_cnt", bus1.SAMPLE_CNT, 32'd0);

    // RUN dropped during SHIFT: the sample completes, then idle.
    wait_rise("cnvst3", SelCnvst1, 300, t3);
    chk("period_250_b", t3 - t2, 32'd250);
    wait_level("sclk3", SelSclk1, 1'b1, 300, at);
    bus1.RUN = 1'b0;
    wait_rise("valid3", SelValid1, 300, at);
    chk("sample3", 32'(bus1.SAMPLE), 32'h15A3C);
    wait_level("idle3", SelActive1, 1'b0, 300, at);
    chk("idle_time", at - t3, 32'd250);
    chk("cnt_after_3", bus1.SAMPLE_CNT, 32'd1);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (bus1.ADCNVST) n++;
    end
    chk("no_cnvst_idle", n, 32'd0);

    // BUSY never rises: timeout, no sample, next CNVST right after GAP.
    busy_en = 1'b0;
    bus1.RUN = 1'b1;
    wait_rise("cnvst4", SelCnvst1, 50, t4);
    wait_level("tmo", SelTmo1, 1'b1, 600, at);
    chk("tmo_time", at - t4, 32'd404);
    chk("tmo_adcs", 32'(bus1.ADCS), 32'd1);
    chk("tmo_no_valid", 32'(bus1.SAMPLE_VALID), 32'd0);
    busy_en = 1'b1;
    adc_word1 = 18'h0C3A5;
    wait_rise("cnvst5", SelCnvst1, 50, t5);
    chk("tmo_next_cnvst", t5 - t4, 32'd405);

    // Reset in the middle of SHIFT.
    wait_level("sclk5", SelSclk1, 1'b1, 300, at);
    bus1.RUN = 1'b0;
    RESETN = 1'b0;
    #1;
    chk("rstmid_sclk", 32'(bus1.ADSCLK), 32'd0);
    chk("rstmid_adcs", 32'(bus1.ADCS), 32'd1);
    chk("rstmid_active", 32'(bus1.ACTIVE), 32'd0);
    chk("rstmid_tmo", 32'(bus1.TIMEOUT_ERR), 32'd0);
    chk("rstmid_cnt", bus1.SAMPLE_CNT, 32'd0);
    chk("rstmid_sample", 32'(bus1.SAMPLE), 32'd0);
    @(negedge CLK);
    RESETN = 1'b1;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (bus1.SAMPLE_VALID || bus1.ADCNVST) n++;
    end
    chk("rstmid_quiet", n, 32'd0);
    adc_word1 = 18'h0F0F0;
    bus1.RUN = 1'b1;
    wait_rise("valid6", SelValid1, 600, at);
    chk("sample_after_rst", 32'(bus1.SAMPLE), 32'h0F0F0);
    bus1.RUN = 1'b0;

    // SCLK_HALF=1 instance with an alternating data pattern.
    f0 = falls2;
    bus2.RUN = 1'b1;
    wait_rise("cnvst2_0", SelCnvst2, 50, t6);
    bus2.RUN = 1'b0;
    n2 = 0; first = 0; last = 0;
    for (int i = 0; i < 400 && !bus2.SAMPLE_VALID; i++) begin
      @(negedge CLK);
      if (bus2.ADSCLK) begin
        if (n2 == 0) first = cyc;
        last = cyc;
        n2++;
      end
    end
    chk("h1_valid", 32'(bus2.SAMPLE_VALID), 32'd1);
    chk("h1_sclk_high_cycles", n2, 32'd18);
    chk("h1_sclk_span", last - first, 32'd34);
    chk("h1_falls", falls2 - f0, 32'd18);
    chk("h1_sample", 32'(bus2.SAMPLE), 32'h2AAAA);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
